// File: rtl/rx_loader_pkg.sv
// rx_loader_pkg: shared types and helpers for the receive-stream image loader.
package rx_loader_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_PAYLOAD,
        ST_CSUM,
        ST_FIN
    } state_t;

    // Default start-of-frame marker
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Byte enables for a word whose highest filled lane is 'lane'
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        case (lane)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rx_byte_loader_if.sv
// rx_byte_loader_if: receive byte stream in, RAM write port and status out.
// master = byte source / system side, slave = the loader.
interface rx_byte_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, mem_be, busy, done, err
    );
endinterface

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs payload bytes little-endian into 32-bit words and
// issues a registered one-cycle write request per full or final partial word.
module rx_word_packer
    import rx_loader_pkg::*;
(
    input  logic        clk_rx,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        last,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        wr_req
);
    logic [1:0]  lane;
    logic [23:0] pack;
    logic [31:0] word_next;

    // Assemble the outgoing word: held lanes below, current byte, zeros above
    always_comb begin
        // NOTE: default first so every path assigns word_next and no latch is inferred.
        word_next = 32'd0;
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < lane) begin
                word_next[8*k +: 8] = pack[8*k +: 8];
            end
        end
        word_next[{lane, 3'b000} +: 8] = in_byte;
    end

    // Lane tracking, pack register and one-cycle write request
    always_ff @(posedge clk_rx or negedge rst_n) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (!rst_n) begin
            lane   <= 2'd0;
            pack   <= 24'd0;
            word   <= 32'd0;
            be     <= 4'b0000;
            wr_req <= 1'b0;
        end else begin
            wr_req <= 1'b0;
            be     <= 4'b0000;
            if (in_valid) begin
                if (lane == 2'd3 || last) begin
                    wr_req <= 1'b1;
                    word   <= word_next;
                    be     <= lane_be(lane);
                    lane   <= 2'd0;
                end else begin
                    pack[{lane, 3'b000} +: 8] <= in_byte;
                    lane                      <= lane + 2'd1;
                end
            end
        end
    end
endmodule

// File: rtl/rx_byte_loader.sv
// rx_byte_loader: parses SOF/LEN/payload/CSUM frames from the receive byte
// stream and writes the payload to RAM as little-endian 32-bit words.
// Optional checksum verification is enabled with `define RX_LOADER_CSUM_EN.
module rx_byte_loader
    import rx_loader_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter int          BASE_ADDR = 0,
    parameter logic [7:0]  SOF       = SOF_DEFAULT
) (
    input logic            clk_rx,
    input logic            rst_n,
    rx_byte_loader_if.slave bus
);
    // Word pointer carries one extra bit so running off the top is visible
    localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_next;
    logic [7:0]      len_h;
    logic [15:0]     remaining;
    logic [ADDR_W:0] word_ptr;
    logic            ovf;
    logic            csum_bad;
    logic            sof_accept;
    logic            pay_valid;
    logic            pay_last;
    logic            mem_we;
    logic [31:0]     pk_word;
    logic [3:0]      pk_be;
    logic            pk_wr;

    assign sof_accept = (state == ST_IDLE) && bus.rx_valid && (bus.rx_data == SOF);
    assign pay_valid  = (state == ST_PAYLOAD) && bus.rx_valid;
    assign pay_last   = (remaining == 16'd1);

    // State register
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; every transition except FIN waits for a valid byte
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (sof_accept) state_next = ST_LEN_H;
            ST_LEN_H:   if (bus.rx_valid) state_next = ST_LEN_L;
            ST_LEN_L:   if (bus.rx_valid) state_next = ({len_h, bus.rx_data} != 16'd0) ? ST_PAYLOAD : ST_CSUM;
            ST_PAYLOAD: if (bus.rx_valid && pay_last) state_next = ST_CSUM;
            ST_CSUM:    if (bus.rx_valid) state_next = ST_FIN;
            ST_FIN:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Length capture and remaining-byte countdown (saturates at zero)
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            len_h     <= 8'd0;
            remaining <= 16'd0;
        end else begin
            if (state == ST_LEN_H && bus.rx_valid) len_h <= bus.rx_data;
            if (state == ST_LEN_L && bus.rx_valid) begin
                remaining <= {len_h, bus.rx_data};
            end else if (pay_valid && remaining != 16'd0) begin
                remaining <= remaining - 16'd1;
            end
        end
    end

    // Word address generation with overflow detection; never wraps
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            word_ptr <= BASE_PTR;
            ovf      <= 1'b0;
        end else if (sof_accept) begin
            word_ptr <= BASE_PTR;
            ovf      <= 1'b0;
        end else if (pk_wr) begin
            if (word_ptr[ADDR_W]) ovf      <= 1'b1;
            else                  word_ptr <= word_ptr + PTR_ONE;
        end
    end

`ifdef RX_LOADER_CSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_sum;

    assign csum_sum = csum + bus.rx_data;

    // Running mod-256 sum over LEN_H, LEN_L, payload and CSUM
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            csum     <= 8'd0;
            csum_bad <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sof_accept) begin
                        csum     <= 8'd0;
                        csum_bad <= 1'b0;
                    end
                end
                ST_LEN_H, ST_LEN_L, ST_PAYLOAD: if (bus.rx_valid) csum <= csum_sum;
                ST_CSUM: if (bus.rx_valid) csum_bad <= (csum_sum != 8'd0);
                default: ;
            endcase
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    rx_word_packer u_packer (
        .clk_rx   (clk_rx),
        .rst_n    (rst_n),
        .in_byte  (bus.rx_data),
        .in_valid (pay_valid),
        .last     (pay_last),
        .word     (pk_word),
        .be       (pk_be),
        .wr_req   (pk_wr)
    );

    assign mem_we        = pk_wr & ~word_ptr[ADDR_W];
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = word_ptr[ADDR_W-1:0];
    assign bus.mem_wdata = pk_word;
    assign bus.mem_be    = mem_we ? pk_be : 4'b0000;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_FIN);
    assign bus.err       = (state == ST_FIN) && (ovf || csum_bad);
endmodule

// File: tb/tb_rx_byte_loader.sv
// tb_rx_byte_loader: directed frames with a scoreboard. Stimulus pushes the
// expected RAM writes and frame completions; monitors on the falling edge pop
// and compare whenever a DUT asserts mem_we or done.
module tb_rx_byte_loader;

`ifdef RX_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk_rx = 1'b0;
    logic rst_n  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    wr_t  exp_wr_a[$];
    wr_t  exp_wr_b[$];
    bit   exp_done_a[$];
    bit   exp_done_b[$];
    wr_t  e_a;
    wr_t  e_b;
    bit   ee_a;
    bit   ee_b;
    bit   prev_done_a = 1'b0;
    bit   prev_done_b = 1'b0;

    always #5 clk_rx = ~clk_rx;

    rx_byte_loader_if #(.ADDR_W(14)) if_a ();
    rx_byte_loader_if #(.ADDR_W(2))  if_b ();

    rx_byte_loader #(.ADDR_W(14), .BASE_ADDR(0), .SOF(8'hA5)) dut (
        .clk_rx (clk_rx),
        .rst_n  (rst_n),
        .bus    (if_a)
    );

    rx_byte_loader #(.ADDR_W(2), .BASE_ADDR(0), .SOF(8'hA5)) dut_small (
        .clk_rx (clk_rx),
        .rst_n  (rst_n),
        .bus    (if_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the full-size instance
    always @(negedge clk_rx) begin
        if (prev_done_a) check("a_busy_fall", if_a.busy, 1'b0);
        prev_done_a = if_a.done;
        if (if_a.mem_we) begin
            if (exp_wr_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_write: got addr=%0h data=%0h be=%0h expected no write",
                         if_a.mem_addr, if_a.mem_wdata, if_a.mem_be);
            end else begin
                e_a = exp_wr_a.pop_front();
                check("a_mem_addr", 64'(if_a.mem_addr), 64'(e_a.addr));
                check("a_mem_wdata", if_a.mem_wdata, e_a.data);
                check("a_mem_be", if_a.mem_be, e_a.be);
            end
        end
        if (if_a.err && !if_a.done) check("a_err_without_done", if_a.done, 1'b1);
        if (if_a.done) begin
            check("a_writes_before_done", exp_wr_a.size(), 0);
            if (exp_done_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_done: got done=1 err=%0b expected no done", if_a.err);
            end else begin
                ee_a = exp_done_a.pop_front();
                check("a_err", if_a.err, ee_a);
            end
        end
    end

    // Monitor for the small-address instance
    always @(negedge clk_rx) begin
        if (prev_done_b) check("b_busy_fall", if_b.busy, 1'b0);
        prev_done_b = if_b.done;
        if (if_b.mem_we) begin
            if (exp_wr_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_write: got addr=%0h data=%0h be=%0h expected no write",
                         if_b.mem_addr, if_b.mem_wdata, if_b.mem_be);
            end else begin
                e_b = exp_wr_b.pop_front();
                check("b_mem_addr", 64'(if_b.mem_addr), 64'(e_b.addr));
                check("b_mem_wdata", if_b.mem_wdata, e_b.data);
                check("b_mem_be", if_b.mem_be, e_b.be);
            end
        end
        if (if_b.err && !if_b.done) check("b_err_without_done", if_b.done, 1'b1);
        if (if_b.done) begin
            check("b_writes_before_done", exp_wr_b.size(), 0);
            if (exp_done_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done: got done=1 err=%0b expected no done", if_b.err);
            end else begin
                ee_b = exp_done_b.pop_front();
                check("b_err", if_b.err, ee_b);
            end
        end
    end

    task automatic send(input bit sel, input logic [7:0] b);
        @(negedge clk_rx);
        if (sel) begin
            if_b.rx_data  = b;
            if_b.rx_valid = 1'b1;
        end else begin
            if_a.rx_data  = b;
            if_a.rx_valid = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_rx);
            if_a.rx_valid = 1'b0;
            if_b.rx_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input bit sel, input logic [7:0] seq[$]);
        foreach (seq[i]) send(sel, seq[i]);
    endtask

    task automatic push_wr(input bit sel, input logic [13:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (sel) exp_wr_b.push_back('{addr: addr, data: data, be: be});
        else     exp_wr_a.push_back('{addr: addr, data: data, be: be});
    endtask

    // Idle the inputs until every expected frame completion has been seen
    task automatic wait_drain();
        int n = 0;
        while ((exp_done_a.size() != 0 || exp_done_b.size() != 0) && n < 200) begin
            idle(1);
            n++;
        end
        check("frame_completion_pending", exp_done_a.size() + exp_done_b.size(), 0);
        idle(3);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        if_a.rx_data  = 8'h00;
        if_a.rx_valid = 1'b0;
        if_b.rx_data  = 8'h00;
        if_b.rx_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_rx);
        check("rst_mem_we", if_a.mem_we, 1'b0);
        check("rst_mem_addr", 64'(if_a.mem_addr), 0);
        check("rst_mem_wdata", if_a.mem_wdata, 32'h0);
        check("rst_mem_be", if_a.mem_be, 4'h0);
        check("rst_busy", if_a.busy, 1'b0);
        check("rst_done", if_a.done, 1'b0);
        check("rst_err", if_a.err, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Five-byte frame, good checksum
        push_wr(0, 14'd0, 32'h44332211, 4'b1111);
        push_wr(0, 14'd1, 32'h00000055, 4'b0001);
        exp_done_a.push_back(1'b0);
        q = {8'hA5, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFC};
        send(0, q[0]);
        idle(1);
        check("busy_after_sof", if_a.busy, 1'b1);
        q.delete(0);
        send_seq(0, q);
        wait_drain();

        // Same frame, bad checksum
        push_wr(0, 14'd0, 32'h44332211, 4'b1111);
        push_wr(0, 14'd1, 32'h00000055, 4'b0001);
        exp_done_a.push_back(CSUM_EN);
        q = {8'hA5, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFD};
        send_seq(0, q);
        wait_drain();

        // Leading junk, zero-length frame
        exp_done_a.push_back(1'b0);
        q = {8'h00, 8'h7E, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(0, q);
        wait_drain();

        // Eight-byte frame with a five-cycle stall after payload byte 3
        push_wr(0, 14'd0, 32'h04030201, 4'b1111);
        push_wr(0, 14'd1, 32'h08070605, 4'b1111);
        exp_done_a.push_back(1'b0);
        q = {8'hA5, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03};
        send_seq(0, q);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("busy_during_stall", if_a.busy, 1'b1);
        end
        q = {8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hD4};
        send_seq(0, q);
        wait_drain();

        // Reset after payload byte 2 of a six-byte frame
        q = {8'hA5, 8'h00, 8'h06, 8'hAA, 8'hBB};
        send_seq(0, q);
        @(negedge clk_rx);
        rst_n         = 1'b0;
        if_a.rx_valid = 1'b0;
        @(negedge clk_rx);
        check("midrst_mem_we", if_a.mem_we, 1'b0);
        check("midrst_mem_addr", 64'(if_a.mem_addr), 0);
        check("midrst_mem_wdata", if_a.mem_wdata, 32'h0);
        check("midrst_busy", if_a.busy, 1'b0);
        rst_n = 1'b1;
        idle(4);
        check("post_rst_no_write", exp_wr_a.size(), 0);

        // Frame after reset loads at the base address
        push_wr(0, 14'd0, 32'h00302010, 4'b0111);
        exp_done_a.push_back(1'b0);
        q = {8'hA5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
        send_seq(0, q);
        wait_drain();

        // Overflow on a four-word RAM: LEN=20, bytes 0..19, correct checksum
        push_wr(1, 14'd0, 32'h03020100, 4'b1111);
        push_wr(1, 14'd1, 32'h07060504, 4'b1111);
        push_wr(1, 14'd2, 32'h0B0A0908, 4'b1111);
        push_wr(1, 14'd3, 32'h0F0E0D0C, 4'b1111);
        exp_done_b.push_back(1'b1);
        q = {8'hA5, 8'h00, 8'h14};
        for (int i = 0; i < 20; i++) q.push_back(8'(i));
        q.push_back(8'h2E);
        send_seq(1, q);
        wait_drain();

        check("final_pending_writes_a", exp_wr_a.size(), 0);
        check("final_pending_writes_b", exp_wr_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
